decode_issue_ctrl: RTL and testbench

Front-end controller that sequences the combinational instruction decoder and schedules decoded instructions into the backend.
- Holds one fetched 16-bit instruction in an instruction register (IR) that drives the decoder.
- Checks the decoder's register and flag usage against a busy-bit scoreboard.
- Issues to the backend over a valid/ready handshake; handles branch flush.
- Sits between the fetch buffer and the issue/execute stage.

---
 rtl/decode_issue_ctrl_pkg.sv | 28 ++
 rtl/decode_issue_ctrl_if.sv | 61 ++++++
 rtl/decode_scoreboard.sv | 63 ++++++
 rtl/decode_issue_ctrl.sv | 112 +++++++++++
 tb/tb_decode_issue_ctrl.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/decode_issue_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : decode_issue_ctrl_pkg
// Description : Shared types and constants for the decode/issue controller:
//               issue FSM state encoding, decoded-instruction word type and
//               default sizing constants.
// Revision    : 1.0 - initial release
// ============================================================================
package decode_issue_ctrl_pkg;

   localparam int WORD_SIZE_DEF  = 16;
   localparam int NUM_REG_DEF    = 16;
   localparam int DEC_WORD_W_DEF = 64;
   localparam int STALL_W_DEF    = 16;
   localparam int REG_ID_W       = $clog2(NUM_REG_DEF);

   // EMPTY: IR holds nothing; READY: IR valid and clear to issue;
   // STALL: IR valid but blocked by a scoreboard hazard.
   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_READY = 2'd1,
      ST_STALL = 2'd2
   } issue_state_e;

   typedef logic [DEC_WORD_W_DEF-1:0] decoded_instruction_t;

endpackage : decode_issue_ctrl_pkg
`default_nettype wire

// File: rtl/decode_issue_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : decode_issue_ctrl_if
// Description : Fetch, decoder, issue, writeback and flush signals of the
//               decode/issue controller. The controller uses the master view,
//               the surrounding pipeline the slave view.
// Revision    : 1.0 - initial release
// ============================================================================
interface decode_issue_ctrl_if #(
   parameter int WORD_SIZE_P               = 16,
   parameter int NUM_REG_P                 = 16,
   parameter int DECODED_INSTRUCTION_WIDTH = 64,
   parameter int STALL_CNT_WIDTH_P         = 16
);
   localparam int REG_ID_W = $clog2(NUM_REG_P);

   // fetch side
   logic                                 fe_v_i;
   logic [WORD_SIZE_P-1:0]               fe_inst_i;
   logic                                 fe_ready_o;
   // decoder side
   logic [WORD_SIZE_P-1:0]               dec_inst_o;
   logic [DECODED_INSTRUCTION_WIDTH-1:0] dec_word_i;
   logic                                 dec_w_v_i;
   logic [REG_ID_W-1:0]                  dec_dest_id_i;
   logic                                 dec_src1_v_i;
   logic [REG_ID_W-1:0]                  dec_src1_id_i;
   logic                                 dec_src2_v_i;
   logic [REG_ID_W-1:0]                  dec_src2_id_i;
   logic                                 dec_flags_w_i;
   logic                                 dec_flags_r_i;
   // issue side
   logic                                 issue_v_o;
   logic [DECODED_INSTRUCTION_WIDTH-1:0] issue_word_o;
   logic                                 issue_ready_i;
   // writeback / redirect
   logic                                 wb_v_i;
   logic [REG_ID_W-1:0]                  wb_id_i;
   logic                                 wb_flags_v_i;
   logic                                 flush_i;
   // status
   logic [STALL_CNT_WIDTH_P-1:0]         stall_cnt_o;

   modport master (
      input  fe_v_i, fe_inst_i, dec_word_i, dec_w_v_i, dec_dest_id_i,
             dec_src1_v_i, dec_src1_id_i, dec_src2_v_i, dec_src2_id_i,
             dec_flags_w_i, dec_flags_r_i, issue_ready_i, wb_v_i, wb_id_i,
             wb_flags_v_i, flush_i,
      output fe_ready_o, dec_inst_o, issue_v_o, issue_word_o, stall_cnt_o
   );

   modport slave (
      output fe_v_i, fe_inst_i, dec_word_i, dec_w_v_i, dec_dest_id_i,
             dec_src1_v_i, dec_src1_id_i, dec_src2_v_i, dec_src2_id_i,
             dec_flags_w_i, dec_flags_r_i, issue_ready_i, wb_v_i, wb_id_i,
             wb_flags_v_i, flush_i,
      input  fe_ready_o, dec_inst_o, issue_v_o, issue_word_o, stall_cnt_o
   );

endinterface : decode_issue_ctrl_if
`default_nettype wire

// File: rtl/decode_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : decode_scoreboard
// Description : Busy-bit scoreboard: one bit per architectural register plus
//               a condition-flags bit. Set on issue of a writer, cleared on
//               writeback; a set and clear of the same bit in one cycle
//               leaves the bit set. Three register read ports, one flag read.
// Revision    : 1.0 - initial release
// ============================================================================
module decode_scoreboard #(
   parameter int NUM_REG_P = 16,
   parameter int REG_ID_W  = $clog2(NUM_REG_P)
) (
   input  wire logic                clk_i,
   input  wire logic                reset_n_i,
   input  wire logic                set_v_i,
   input  wire logic [REG_ID_W-1:0] set_id_i,
   input  wire logic                clr_v_i,
   input  wire logic [REG_ID_W-1:0] clr_id_i,
   input  wire logic                flag_set_i,
   input  wire logic                flag_clr_i,
   input  wire logic [REG_ID_W-1:0] rd1_id_i,
   input  wire logic [REG_ID_W-1:0] rd2_id_i,
   input  wire logic [REG_ID_W-1:0] rd3_id_i,
   output logic                     rd1_busy_o,
   output logic                     rd2_busy_o,
   output logic                     rd3_busy_o,
   output logic                     flags_busy_o
);

   logic [NUM_REG_P-1:0] r_busy;
   logic                 r_flags_busy;
   logic [NUM_REG_P-1:0] w_set_vec;
   logic [NUM_REG_P-1:0] w_clr_vec;

   // One-hot set and clear masks from the issue and writeback ids
   always_comb begin
      w_set_vec = '0;
      w_clr_vec = '0;
      for (int i = 0; i < NUM_REG_P; i++) begin
         w_set_vec[i] = set_v_i & (set_id_i == REG_ID_W'(i));
         w_clr_vec[i] = clr_v_i & (clr_id_i == REG_ID_W'(i));
      end
   end

   // Busy bits: clear applied first, set ORed in last so set wins
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         r_busy       <= '0;
         r_flags_busy <= 1'b0;
      end else begin
         r_busy       <= (r_busy & ~w_clr_vec) | w_set_vec;
         r_flags_busy <= (r_flags_busy & ~flag_clr_i) | flag_set_i;
      end
   end

   assign rd1_busy_o   = r_busy[rd1_id_i];
   assign rd2_busy_o   = r_busy[rd2_id_i];
   assign rd3_busy_o   = r_busy[rd3_id_i];
   assign flags_busy_o = r_flags_busy;

endmodule : decode_scoreboard
`default_nettype wire

// File: rtl/decode_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : decode_issue_ctrl
// Description : Front-end controller. Holds one fetched instruction in the IR
//               feeding the decoder, checks decoded register/flag usage
//               against the scoreboard, issues over valid/ready and handles
//               branch flush. Counts hazard-stall cycles (saturating).
// Revision    : 1.0 - initial release
// ============================================================================
module decode_issue_ctrl
   import decode_issue_ctrl_pkg::*;
#(
   parameter int WORD_SIZE_P               = WORD_SIZE_DEF,
   parameter int NUM_REG_P                 = NUM_REG_DEF,
   parameter int DECODED_INSTRUCTION_WIDTH = DEC_WORD_W_DEF,
   parameter int STALL_CNT_WIDTH_P         = STALL_W_DEF
) (
   input  wire logic           clk_i,
   input  wire logic           reset_n_i,
   decode_issue_ctrl_if.master bus
);

   localparam int                           C_REG_ID_W = $clog2(NUM_REG_P);
   localparam logic [STALL_CNT_WIDTH_P-1:0] C_CNT_ONE  = STALL_CNT_WIDTH_P'(1);

   logic [WORD_SIZE_P-1:0]       r_ir;
   logic                         r_ir_v;
   logic [STALL_CNT_WIDTH_P-1:0] r_stall_cnt;

   logic         w_src1_busy;
   logic         w_src2_busy;
   logic         w_dest_busy;
   logic         w_flags_busy;
   logic         w_hazard;
   logic         w_issue_v;
   logic         w_issue_fire;
   logic         w_fe_ready;
   logic         w_fe_accept;
   issue_state_e w_state;

   decode_scoreboard #(
      .NUM_REG_P (NUM_REG_P),
      .REG_ID_W  (C_REG_ID_W)
   ) u_scoreboard (
      .clk_i        (clk_i),
      .reset_n_i    (reset_n_i),
      .set_v_i      (w_issue_fire & bus.dec_w_v_i),
      .set_id_i     (bus.dec_dest_id_i),
      .clr_v_i      (bus.wb_v_i),
      .clr_id_i     (bus.wb_id_i),
      .flag_set_i   (w_issue_fire & bus.dec_flags_w_i),
      .flag_clr_i   (bus.wb_flags_v_i),
      .rd1_id_i     (bus.dec_src1_id_i),
      .rd2_id_i     (bus.dec_src2_id_i),
      .rd3_id_i     (bus.dec_dest_id_i),
      .rd1_busy_o   (w_src1_busy),
      .rd2_busy_o   (w_src2_busy),
      .rd3_busy_o   (w_dest_busy),
      .flags_busy_o (w_flags_busy)
   );

   // Hazard check on registered busy bits only, then handshake and state.
   // Flags are checked for both read and write so flag updates stay ordered.
   always_comb begin
      w_hazard     = (bus.dec_src1_v_i  & w_src1_busy)
                   | (bus.dec_src2_v_i  & w_src2_busy)
                   | (bus.dec_w_v_i     & w_dest_busy)
                   | (bus.dec_flags_r_i & w_flags_busy)
                   | (bus.dec_flags_w_i & w_flags_busy);
      w_issue_v    = r_ir_v & ~w_hazard & ~bus.flush_i;
      w_issue_fire = w_issue_v & bus.issue_ready_i;
      w_fe_ready   = (~r_ir_v | w_issue_fire) & ~bus.flush_i;
      w_fe_accept  = bus.fe_v_i & w_fe_ready;
      if (!r_ir_v) begin
         w_state = ST_EMPTY;
      end else if (w_hazard) begin
         w_state = ST_STALL;
      end else begin
         w_state = ST_READY;
      end
   end

   // Instruction register: load on accept, drop on issue or flush
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         r_ir   <= '0;
         r_ir_v <= 1'b0;
      end else if (w_fe_accept) begin
         r_ir   <= bus.fe_inst_i;
         r_ir_v <= 1'b1;
      end else if (w_issue_fire | bus.flush_i) begin
         r_ir_v <= 1'b0;
      end
   end

   // Saturating count of cycles spent in STALL
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         r_stall_cnt <= '0;
      end else if ((w_state == ST_STALL) && (r_stall_cnt != '1)) begin
         r_stall_cnt <= r_stall_cnt + C_CNT_ONE;
      end
   end

   assign bus.fe_ready_o   = w_fe_ready;
   assign bus.dec_inst_o   = r_ir;
   assign bus.issue_v_o    = w_issue_v;
   assign bus.issue_word_o = bus.dec_word_i;
   assign bus.stall_cnt_o  = r_stall_cnt;

endmodule : decode_issue_ctrl
`default_nettype wire

// File: tb/tb_decode_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_decode_issue_ctrl
// Description : Self-checking bench for decode_issue_ctrl. A toy decoder maps
//               IR bits to register/flag usage; a reference model tracks IR
//               occupancy, busy registers and the stall count cycle by cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_decode_issue_ctrl;

   localparam int W  = 16;
   localparam int NR = 16;
   localparam int DW = 64;
   localparam int CW = 16;

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   decode_issue_ctrl_if #(
      .WORD_SIZE_P(W), .NUM_REG_P(NR),
      .DECODED_INSTRUCTION_WIDTH(DW), .STALL_CNT_WIDTH_P(CW)
   ) bus ();

   decode_issue_ctrl #(
      .WORD_SIZE_P(W), .NUM_REG_P(NR),
      .DECODED_INSTRUCTION_WIDTH(DW), .STALL_CNT_WIDTH_P(CW)
   ) dut (
      .clk_i     (clk),
      .reset_n_i (rst_n),
      .bus       (bus)
   );

   // Toy instruction format: [3:0] dest, [7:4] src1, [11:8] src2,
   // [12] writes dest, [13] src1 valid, [14] src2 valid,
   // [15] flag op: flag write when [14]=0, flag read (branch) when [14]=1.
   function automatic logic [DW-1:0] dec_word(input logic [W-1:0] x);
      return {~x, x ^ 16'hA5A5, x, {x[7:0], x[15:8]} ^ 16'h1234};
   endfunction

   function automatic bit f_w(input logic [W-1:0] x);
      return x[15] & ~x[14];
   endfunction

   function automatic bit f_r(input logic [W-1:0] x);
      return x[15] & x[14];
   endfunction

   function automatic logic [W-1:0] mk(input bit fop, input bit s2v,
                                       input bit s1v, input bit wv,
                                       input logic [3:0] s2,
                                       input logic [3:0] s1,
                                       input logic [3:0] d);
      return {fop, s2v, s1v, wv, s2, s1, d};
   endfunction

   // Decoder stand-in driven from the DUT's IR
   always_comb begin
      bus.dec_word_i    = dec_word(bus.dec_inst_o);
      bus.dec_dest_id_i = bus.dec_inst_o[3:0];
      bus.dec_src1_id_i = bus.dec_inst_o[7:4];
      bus.dec_src2_id_i = bus.dec_inst_o[11:8];
      bus.dec_w_v_i     = bus.dec_inst_o[12];
      bus.dec_src1_v_i  = bus.dec_inst_o[13];
      bus.dec_src2_v_i  = bus.dec_inst_o[14];
      bus.dec_flags_w_i = f_w(bus.dec_inst_o);
      bus.dec_flags_r_i = f_r(bus.dec_inst_o);
   end

   // Reference model state
   bit         m_busy [NR];
   bit         m_fbusy;
   bit         m_ir_v;
   logic [W-1:0] m_ir;
   int         m_cnt;

   int n_tests = 0;
   int n_fail  = 0;
   bit last_iv, last_fire, last_rdy;
   int nfire;

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      foreach (m_busy[i]) m_busy[i] = 1'b0;
      m_fbusy = 1'b0;
      m_ir_v  = 1'b0;
      m_ir    = '0;
      m_cnt   = 0;
   endtask

   function automatic bit m_hazard(input logic [W-1:0] x);
      return (x[13] && m_busy[x[7:4]]) || (x[14] && m_busy[x[11:8]]) ||
             (x[12] && m_busy[x[3:0]]) || ((f_r(x) || f_w(x)) && m_fbusy);
   endfunction

   // One clock cycle: drive inputs, compare outputs, advance the model
   task automatic step(input bit fe_v, input logic [W-1:0] inst,
                       input bit rdy, input bit wbv, input logic [3:0] wbid,
                       input bit wbf, input bit fl);
      bit           haz, exp_iv, fire, exp_rdy;
      logic [W-1:0] x;
      @(negedge clk);
      bus.fe_v_i        = fe_v;
      bus.fe_inst_i     = inst;
      bus.issue_ready_i = rdy;
      bus.wb_v_i        = wbv;
      bus.wb_id_i       = wbid;
      bus.wb_flags_v_i  = wbf;
      bus.flush_i       = fl;
      #1;
      x       = m_ir;
      haz     = m_ir_v && m_hazard(x);
      exp_iv  = m_ir_v && !haz && !fl;
      fire    = exp_iv && rdy;
      exp_rdy = (!m_ir_v || fire) && !fl;
      check("issue_v", bus.issue_v_o, exp_iv);
      check("fe_ready", bus.fe_ready_o, exp_rdy);
      check("dec_inst", bus.dec_inst_o, m_ir);
      check("stall_cnt", bus.stall_cnt_o, m_cnt);
      if (exp_iv) check("issue_word", bus.issue_word_o, dec_word(x));
      last_iv   = bus.issue_v_o;
      last_fire = bus.issue_v_o & rdy;
      last_rdy  = bus.fe_ready_o;
      @(posedge clk);
      if (haz) m_cnt = (m_cnt >= 65535) ? 65535 : m_cnt + 1;
      if (wbv) m_busy[wbid] = 1'b0;
      if (wbf) m_fbusy = 1'b0;
      if (fire && x[12]) m_busy[x[3:0]] = 1'b1;
      if (fire && f_w(x)) m_fbusy = 1'b1;
      if (fe_v && exp_rdy) begin
         m_ir   = inst;
         m_ir_v = 1'b1;
      end else if (fire || fl) begin
         m_ir_v = 1'b0;
      end
   endtask

   task automatic idle();
      step(1'b0, '0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
   endtask

   // Write back every register and the flags so the scoreboard is empty
   task automatic drain();
      for (int i = 0; i < NR; i++) step(1'b0, '0, 1'b1, 1'b1, 4'(i), 1'b1, 1'b0);
   endtask

   initial begin
      rst_n             = 1'b0;
      bus.fe_v_i        = 1'b0;
      bus.fe_inst_i     = '0;
      bus.issue_ready_i = 1'b0;
      bus.wb_v_i        = 1'b0;
      bus.wb_id_i       = '0;
      bus.wb_flags_v_i  = 1'b0;
      bus.flush_i       = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check("rst_issue_v", bus.issue_v_o, 1'b0);
      check("rst_fe_ready", bus.fe_ready_o, 1'b1);
      check("rst_dec_inst", bus.dec_inst_o, 16'h0);
      check("rst_stall_cnt", bus.stall_cnt_o, 16'h0);
      @(negedge clk);
      rst_n = 1'b1;

      // Back-to-back independent ALU ops: one issue per cycle after 1 cycle
      nfire = 0;
      for (int i = 0; i < 6; i++) begin
         step(1'b1, mk(0, 1, 1, 1, 4'd11, 4'd10, 4'(i)), 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
         if (i == 0) check("b2b_first_no_issue", last_iv, 1'b0);
         nfire += int'(last_fire);
      end
      idle();
      nfire += int'(last_fire);
      check("b2b_fire_count", nfire, 6);
      check("b2b_stall_cnt", bus.stall_cnt_o, 16'h0);
      drain();

      // RAW on r3: writeback in the fifth stalled cycle
      step(1'b1, mk(0, 0, 0, 1, 4'd0, 4'd0, 4'd3), 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
      step(1'b1, mk(0, 0, 1, 0, 4'd0, 4'd3, 4'd7), 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
      for (int k = 0; k < 5; k++) begin
         step(1'b0, '0, 1'b1, k == 4, 4'd3, 1'b0, 1'b0);
         check("raw_held", last_iv, 1'b0);
      end
      idle();
      check("raw_issue_after_wb", last_fire, 1'b1);
      check("raw_stall_cnt", bus.stall_cnt_o, 16'd5);

      // Flags: compare then conditional branch held until flag writeback
      step(1'b1, mk(1, 0, 0, 0, 4'd0, 4'd0, 4'd0), 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
      step(1'b1, mk(1, 1, 0, 0, 4'd9, 4'd0, 4'd0), 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
      for (int k = 0; k < 3; k++) begin
         step(1'b0, '0, 1'b1, 1'b0, 4'd0, k == 2, 1'b0);
         check("flag_held", last_iv, 1'b0);
      end
      idle();
      check("flag_issue_after_wb", last_fire, 1'b1);

      // Same-cycle writeback of r5 and issue of a new r5 writer: set wins
      drain();
      step(1'b1, mk(0, 0, 0, 1, 4'd0, 4'd0, 4'd5), 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
      step(1'b1, mk(0, 0, 1, 0, 4'd0, 4'd5, 4'd8), 1'b1, 1'b1, 4'd5, 1'b0, 1'b0);
      idle();
      check("setwins_reader_stalls", last_iv, 1'b0);
      step(1'b0, '0, 1'b1, 1'b1, 4'd5, 1'b0, 1'b0);

      // Flush while stalled on r2
      drain();
      step(1'b1, mk(0, 0, 0, 1, 4'd0, 4'd0, 4'd2), 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
      step(1'b1, mk(0, 0, 1, 0, 4'd0, 4'd2, 4'd8), 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
      idle();
      step(1'b1, mk(0, 0, 1, 0, 4'd0, 4'd9, 4'd8), 1'b1, 1'b0, 4'd0, 1'b0, 1'b1);
      check("flush_no_issue", last_iv, 1'b0);
      check("flush_fe_blocked", last_rdy, 1'b0);
      step(1'b1, mk(0, 0, 1, 0, 4'd0, 4'd9, 4'd8), 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
      check("flush_ir_empty", last_iv, 1'b0);
      check("flush_accept_next", last_rdy, 1'b1);
      step(1'b1, mk(0, 0, 1, 0, 4'd0, 4'd2, 4'd8), 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
      check("flush_next_issues", last_fire, 1'b1);
      idle();
      check("flush_busy_kept", last_iv, 1'b0);

      // Randomized traffic against the model
      drain();
      for (int n = 0; n < 3000; n++) begin
         step(($urandom % 4) != 0, 16'($urandom), ($urandom % 4) != 0,
              ($urandom % 3) == 0, 4'($urandom), ($urandom % 4) == 0,
              ($urandom % 16) == 0);
      end

      // Saturate the stall counter, then reset asynchronously mid-stall
      drain();
      step(1'b1, mk(0, 0, 0, 1, 4'd0, 4'd0, 4'd2), 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
      step(1'b1, mk(0, 0, 1, 0, 4'd0, 4'd2, 4'd8), 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
      for (int k = 0; k < 65540; k++) idle();
      #1;
      check("sat_stall_cnt", bus.stall_cnt_o, 16'hFFFF);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_issue_v", bus.issue_v_o, 1'b0);
      check("arst_stall_cnt", bus.stall_cnt_o, 16'h0);
      check("arst_dec_inst", bus.dec_inst_o, 16'h0);
      check("arst_fe_ready", bus.fe_ready_o, 1'b1);
      model_reset();
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      step(1'b1, mk(0, 0, 1, 0, 4'd0, 4'd2, 4'd8), 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
      idle();
      check("arst_busy_cleared", last_fire, 1'b1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_decode_issue_ctrl
`default_nettype wire
